// File: rtl/nios_system_button_in_pio.sv
// Avalon-MM input PIO: synchronized, debounced button inputs with
// edge capture and a maskable level interrupt.
module nios_system_button_in_pio #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int HOLD = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
    localparam int CW   = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(HOLD - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nx;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [CW-1:0]    cnt    [WIDTH];
    logic [CW-1:0]    cnt_nx [WIDTH];
    logic             wr;
    logic             mask_we;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign mask_we      = wr && (address == 2'd2);
    assign clr          = (wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // A toggle pending in sync1 restarts the count so a new level starts fresh.
    always_comb begin
        stable_nx = stable;
        cnt_nx    = cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == stable[i]) begin
                cnt_nx[i] = '0;
            end else if (cnt[i] == CMAX) begin
                stable_nx[i] = sync2[i];
                cnt_nx[i]    = '0;
            end else if (sync1[i] != sync2[i]) begin
                cnt_nx[i] = '0;
            end else begin
                cnt_nx[i] = cnt[i] + CW'(1);
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            1:       edge_hit = ~stable & prev;
            2:       edge_hit = stable ^ prev;
            default: edge_hit = stable & ~prev;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            prev        <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1       <= in_port;
            sync2       <= sync1;
            stable      <= stable_nx;
            prev        <= stable;
            edgecapture <= edge_hit | (edgecapture & ~clr);
            if (mask_we) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nx[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable;
            2'd2:    readdata[WIDTH-1:0] = irqmask;
            2'd3:    readdata[WIDTH-1:0] = edgecapture;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule
